i_cache: RTL
============

// Module: i_cache
// PURPOSE
//   Direct-mapped, one-word-per-line instruction cache between the IF stage and the memory controller.
//   IF presents a fetch address every cycle; a hit returns the instruction combinationally in that cycle.
//   A miss runs a single refill request to the memory controller and writes the returned word into the line.
//   A miss stalls IF: inst_available stays low until the word arrives.
// PARAMETERS
//   LINES     64  number of cache lines, power of 2; IDX_W = log2(LINES)
//   ADDR_LEN  32  address width
//   INST_LEN  32  instruction width
// PORTS
//   clk             in   1         clock, rising edge
//   rst             in   1         reset, synchronous, active-high
//   addr            in   ADDR_LEN  fetch address from IF
//   inst_available  out  1         inst valid for addr this cycle
//   inst            out  INST_LEN  fetched instruction; 0 when inst_available=0
//   mem_req         out  1         refill request to memory controller (level)
//   mem_addr        out  ADDR_LEN  refill word address, bits[1:0]=0
//   mem_valid       in   1         one-cycle pulse: mem_data holds the requested word
//   mem_data        in   INST_LEN  refill data
// BEHAVIOUR
//   - Address split: addr[1:0] ignored; index = addr[IDX_W+1:2]; tag = addr[ADDR_LEN-1:IDX_W+2].
//   - Storage: per line one valid bit, one tag and one data word. Lines are written only on a refill.
//   - hit = valid[index] && tag[index]==tag(addr). A hit is combinational, with zero latency:
//     inst_available=1 and inst=data[index] in the same cycle.
//   - FSM has two states, IDLE and WAIT. State, miss_addr and valid bits are registered.
//     IDLE: on a miss, capture miss_addr={addr[ADDR_LEN-1:2],2'b00} and go to WAIT at the next edge; on a hit, stay.
//     WAIT: mem_req=1 and mem_addr=miss_addr, both held stable until mem_valid.
//       On mem_valid: write valid/tag/data at the index of miss_addr, then go to IDLE at the next edge.
//   - mem_req=0 and mem_addr=0 in IDLE. Consequently mem_req drops for at least one cycle between two refills.
//   - Bypass: in WAIT with mem_valid=1, if addr matches miss_addr (ignoring bits[1:0]),
//     then inst_available=1 and inst=mem_data in that same cycle.
//   - Address change during WAIT (for example a branch redirect): the outstanding refill still
//     completes and fills the line for miss_addr. inst_available=0 unless addr hits a different line.
//     If addr still misses afterwards, a new refill starts via IDLE.
//   - mem_valid while in IDLE is ignored: no write, no state change.
//   - Hits in WAIT on other lines are served normally; the refill continues.
//   - Miss-to-use latency: miss in cycle 0; mem_req asserted from cycle 1; the word is usable in the cycle mem_valid arrives.
//   - Reset: state=IDLE, all valid bits cleared in one cycle, miss_addr=0.
//     Outputs during and after reset: inst_available=0, inst=0, mem_req=0, mem_addr=0.
//     The data and tag arrays are not reset.
//   - Reset during WAIT aborts the refill: mem_req=0 from the next cycle, and a late mem_valid is ignored.
//   - rst and mem_valid in the same cycle: rst wins and nothing is written.
// TESTING
//   1. After reset, addr=0x0 -> inst_available=0; from the next cycle mem_req=1 and mem_addr=0x0.
//      Pulse mem_valid with mem_data=0x00000013 three cycles later -> inst_available=1, inst=0x13 in that cycle.
//      Next cycle: hit and mem_req=0.
//   2. Conflict (LINES=64): fill 0x000, then fill 0x100 (both index 0) -> addr 0x000 misses again.
//      mem_addr=0x000 is re-requested.
//   3. Miss on 0x004, then addr changes to 0x008 before mem_valid -> mem_valid cycle gives inst_available=0.
//      0x004 is filled. mem_req=0 for one cycle, then mem_req=1 with mem_addr=0x008.
//   4. rst asserted in WAIT for 0x010 -> mem_req=0 on the next cycle; a subsequent mem_valid is ignored.
//      A previously filled 0x000 now misses.
//   5. With 0x004 cached, addr=0x006 -> hit, inst=data of 0x004, mem_req stays 0.
//   6. In WAIT for 0x020, addr=0x000 (cached) -> inst_available=1 immediately; the refill of 0x020 still completes.

Source files
------------

// File: rtl/i_cache_if.sv
// Fetch-side and refill-side signals of the instruction cache, bundled for port connection.
// The slave modport is the cache; the master modport is the IF stage plus memory controller.
interface i_cache_if #(
  parameter int ADDR_LEN = 32,
  parameter int INST_LEN = 32
);
  logic [ADDR_LEN-1:0] addr;
  logic                inst_available;
  logic [INST_LEN-1:0] inst;
  logic                mem_req;
  logic [ADDR_LEN-1:0] mem_addr;
  logic                mem_valid;
  logic [INST_LEN-1:0] mem_data;

  // mem_req is a level held with a stable mem_addr until the one-cycle mem_valid
  // pulse; mem_data is only meaningful while mem_valid is high.
  modport slave (
    input  addr, mem_valid, mem_data,
    output inst_available, inst, mem_req, mem_addr
  );

  modport master (
    output addr, mem_valid, mem_data,
    input  inst_available, inst, mem_req, mem_addr
  );
endinterface

// File: rtl/i_cache.sv
// Direct-mapped, one-word-per-line instruction cache with combinational hit path,
// a single outstanding refill and a same-cycle bypass of the returning word.
module i_cache #(
  parameter int LINES    = 64,
  parameter int ADDR_LEN = 32,
  parameter int INST_LEN = 32
) (
  input  logic clk,
  input  logic rst,
  i_cache_if.slave bus,
  output logic state_dbg
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_LEN - IDX_W - 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_LEN-1:0] miss_addr;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [INST_LEN-1:0] data_mem [LINES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;
  logic             hit;
  logic             bypass;
  logic             capture;
  logic             fill;
  logic [1:0]       unused_addr_bits;

  assign idx      = bus.addr[IDX_W+1:2];
  assign tag      = bus.addr[ADDR_LEN-1:IDX_W+2];
  assign miss_idx = miss_addr[IDX_W+1:2];
  assign miss_tag = miss_addr[ADDR_LEN-1:IDX_W+2];
  assign unused_addr_bits = bus.addr[1:0];

  assign hit    = valid_q[idx] && (tag_mem[idx] == tag);
  // The word arriving for the outstanding miss can be forwarded before it lands in the array.
  assign bypass = (state_q == S_WAIT) && bus.mem_valid &&
                  (bus.addr[ADDR_LEN-1:2] == miss_addr[ADDR_LEN-1:2]);

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    fill    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!hit) begin
          state_d = S_WAIT;
          capture = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.mem_valid) begin
          state_d = S_IDLE;
          fill    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every output is forced quiet while rst is high, including a hit on stale lines.
  always_comb begin
    bus.inst_available = 1'b0;
    bus.inst           = '0;
    bus.mem_req        = 1'b0;
    bus.mem_addr       = '0;
    if (!rst) begin
      if (hit) begin
        bus.inst_available = 1'b1;
        bus.inst           = data_mem[idx];
      end else if (bypass) begin
        bus.inst_available = 1'b1;
        bus.inst           = bus.mem_data;
      end
      if (state_q == S_WAIT) begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = miss_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      miss_addr <= '0;
      valid_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        miss_addr <= {bus.addr[ADDR_LEN-1:2], 2'b00};
      end
      if (fill) begin
        valid_q[miss_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (!rst && fill) begin
      tag_mem[miss_idx]  <= miss_tag;
      data_mem[miss_idx] <= bus.mem_data;
    end
  end

  assign state_dbg = state_q;
endmodule
